dmem_arbiter: RTL



---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_arbiter_rr_arb2.sv | 47 ++++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: port identifiers, default
// widths, the implemented memory depth and the registered response record.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int MEM_WORDS  = 128;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // One accepted access, carried into the following cycle to build the
  // response pulse on the port that issued it.
  typedef struct packed {
    logic valid;
    logic port;
    logic we;
    logic err;
  } rsp_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker. A lone requester always wins; on a tie the port
// held in prio wins, and prio then moves to the other port.
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset (prio -> port 0)
//   valid_i  in   [1:0] request valids, bit N = port N
//   gnt_o    out  [1:0] one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    // Hand the tie-break to the loser; hold it when nothing was granted.
    if (gnt_o[0]) begin
      prio_d = PORT_AUX;
    end else if (gnt_o[1]) begin
      prio_d = PORT_CPU;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= PORT_CPU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory (synchronous write, registered read)
// between the CPU load/store path (port 0) and a secondary master (port 1).
// At most one access is accepted per cycle; each accepted access gets a
// one-cycle response pulse on its own port in the following cycle.
//   clk_i / rst_ni             clock, asynchronous active-low reset
//   reqN_valid_i/we_i/addr_i/wdata_i  request from port N (held until ready)
//   reqN_ready_o               access accepted this cycle
//   rspN_valid_o/rdata_o/err_o response for port N (rdata 0 for writes/errors)
//   mem_addr_o/write_data_o/write_o/read_o  memory pins
//   mem_data_out_i             registered memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = dmem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W    = dmem_arb_pkg::DEF_DATA_W,
  parameter int MEM_WORDS = dmem_arb_pkg::MEM_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              req0_valid_i,
  input  logic              req0_we_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              req0_ready_o,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp0_rdata_o,
  output logic              rsp0_err_o,

  input  logic              req1_valid_i,
  input  logic              req1_we_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              req1_ready_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp1_rdata_o,
  output logic              rsp1_err_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_data_out_i
);

  // Full-width compare: addresses above the memory never alias into it.
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS);

  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  rsp_t rsp_q;
  rsp_t rsp_d;

  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_err;
  logic [DATA_W-1:0] rsp_rdata [2];
  logic [DATA_W-1:0] rdata_pass;

  rr_arb2 u_rr_arb2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i ({req1_valid_i, req0_valid_i}),
    .gnt_o   (gnt)
  );

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign any_gnt      = |gnt;

  // Request mux: the grant is one-hot, so gnt[1] alone selects the port.
  always_comb begin
    sel_port  = gnt[1];
    sel_we    = req0_we_i;
    sel_addr  = req0_addr_i;
    sel_wdata = req0_wdata_i;
    if (gnt[1]) begin
      sel_we    = req1_we_i;
      sel_addr  = req1_addr_i;
      sel_wdata = req1_wdata_i;
    end
  end

  assign in_range = (sel_addr < ADDR_LIMIT);

  // Memory pins are forced to zero when idle; strobes are also suppressed for
  // out-of-range accesses so the memory is never touched by them.
  always_comb begin
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    mem_write_o      = 1'b0;
    mem_read_o       = 1'b0;
    if (any_gnt) begin
      mem_addr_o       = sel_addr;
      mem_write_data_o = sel_wdata;
      mem_write_o      = in_range && sel_we;
      mem_read_o       = in_range && !sel_we;
    end
  end

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = any_gnt;
    rsp_d.port  = sel_port;
    rsp_d.we    = sel_we;
    rsp_d.err   = any_gnt && !in_range;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Read data is the memory's registered output, valid in the response cycle.
  assign rdata_pass = (rsp_q.valid && !rsp_q.we && !rsp_q.err) ? mem_data_out_i : '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic hit;
    assign hit           = rsp_q.valid && (rsp_q.port == 1'(gi));
    assign rsp_valid[gi] = hit;
    assign rsp_err[gi]   = hit && rsp_q.err;
    assign rsp_rdata[gi] = hit ? rdata_pass : '0;
  end

  assign rsp0_valid_o = rsp_valid[PORT_CPU];
  assign rsp0_err_o   = rsp_err[PORT_CPU];
  assign rsp0_rdata_o = rsp_rdata[PORT_CPU];
  assign rsp1_valid_o = rsp_valid[PORT_AUX];
  assign rsp1_err_o   = rsp_err[PORT_AUX];
  assign rsp1_rdata_o = rsp_rdata[PORT_AUX];

endmodule
